// File: rtl/multichan_siggen_if.sv
`default_nettype none
// ============================================================================
// Module   : multichan_siggen_if
// Brief    : Configuration and sample-stream bundle for multichan_siggen.
// Revision : 1.0 - initial release
// ============================================================================
interface multichan_siggen_if #(
    parameter int NCH       = 4,
    parameter int ACC_WIDTH = 16,
    parameter int D_WIDTH   = 8,
    parameter int CH_W      = (NCH > 1) ? $clog2(NCH) : 1
);
    logic                 en;
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [CH_W-1:0]      cfg_ch;
    logic                 cfg_sel;
    logic [ACC_WIDTH-1:0] cfg_data;
    logic [D_WIDTH-1:0]   dout;
    logic [CH_W-1:0]      dout_ch;
    logic                 dout_valid;
    logic                 busy;
    logic                 overrun;

    modport master (
        output en, cfg_valid, cfg_ch, cfg_sel, cfg_data,
        input  cfg_ready, dout, dout_ch, dout_valid, busy, overrun
    );

    modport slave (
        input  en, cfg_valid, cfg_ch, cfg_sel, cfg_data,
        output cfg_ready, dout, dout_ch, dout_valid, busy, overrun
    );
endinterface
`default_nettype wire

// File: rtl/multichan_siggen.sv
`default_nettype none
// ============================================================================
// Module   : multichan_siggen
// Brief    : NCH-channel DDS sine generator sharing one time-multiplexed ROM.
//            Define QUARTER_WAVE_EN for a quarter-wave ROM (+1 cycle latency).
// Revision : 1.0 - initial release
// ============================================================================
module multichan_siggen #(
    parameter int NCH       = 4,
    parameter int ACC_WIDTH = 16,
    parameter int A_WIDTH   = 8,
    parameter int D_WIDTH   = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,
    multichan_siggen_if.slave bus
);
    localparam int                     c_CH_W   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [c_CH_W-1:0]      c_LAST   = c_CH_W'(NCH - 1);
    localparam int                     c_Q      = 2 ** (A_WIDTH - 2);
    localparam int                     c_FB     = 28;
    localparam logic signed [63:0]     c_PI_FIX = 64'sd843314857;
    localparam logic [0:0]             c_S_IDLE = 1'b0;
    localparam logic [0:0]             c_S_SCAN = 1'b1;

    // Rounded first-quadrant sample for angle (pi/2)*m/Q, fixed-point Taylor series.
    function automatic int quarter_val(input int m);
        logic signed [63:0] x;
        logic signed [63:0] term;
        logic signed [63:0] sum;
        logic signed [63:0] val;
        x    = (c_PI_FIX * 64'(m)) / 64'(2 * c_Q);
        term = x;
        sum  = x;
        for (int k = 1; k <= 9; k++) begin
            term = (term * x) >>> c_FB;
            term = (term * x) >>> c_FB;
            term = -(term / 64'(2 * k * (2 * k + 1)));
            sum  = sum + term;
        end
        val = (64'(2 ** (D_WIDTH - 1)) <<< c_FB)
            + 64'(2 ** (D_WIDTH - 1) - 1) * sum
            + (64'sd1 <<< (c_FB - 1));
        return int'(val >>> c_FB);
    endfunction

    // Full-table entry derived from the quarter table so both ROM styles agree bit for bit.
    function automatic int sine_val(input int a);
        int q;
        int r;
        int v;
        q = a / c_Q;
        r = a % c_Q;
        case (q)
            0:       v = quarter_val(r);
            1:       v = quarter_val(c_Q - r);
            2:       v = 2 ** D_WIDTH - quarter_val(r);
            default: v = 2 ** D_WIDTH - quarter_val(c_Q - r);
        endcase
        return v;
    endfunction

    logic [0:0]           r_state;
    logic [0:0]           w_state_nxt;
    logic [c_CH_W-1:0]    r_idx;
    logic                 w_busy;
    logic                 w_start;
    logic                 w_ovr_set;
    logic                 w_cfg_fire;
    logic                 r_overrun;
    logic [ACC_WIDTH-1:0] r_acc   [NCH];
    logic [ACC_WIDTH-1:0] r_freq  [NCH];
    logic [ACC_WIDTH-1:0] r_phase [NCH];
    logic [A_WIDTH-1:0]   w_addr;
    logic [D_WIDTH-1:0]   r_dout;
    logic [c_CH_W-1:0]    r_dout_ch;
    logic                 r_dout_valid;

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: if (bus.en) w_state_nxt = c_S_SCAN;
            c_S_SCAN: if (r_idx == c_LAST) w_state_nxt = c_S_IDLE;
            default:  w_state_nxt = c_S_IDLE;
        endcase
    end

    always_comb begin
        w_busy    = 1'b0;
        w_start   = 1'b0;
        w_ovr_set = 1'b0;
        case (r_state)
            c_S_IDLE: w_start = bus.en;
            c_S_SCAN: begin
                w_busy    = 1'b1;
                w_ovr_set = bus.en;
            end
            default: ;
        endcase
    end

    assign w_cfg_fire = bus.cfg_valid && !w_busy;

    always_ff @(posedge clk) begin
        if (rst || w_start)  r_idx <= '0;
        else if (w_busy)     r_idx <= (r_idx == c_LAST) ? '0 : r_idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)            r_overrun <= 1'b0;
        else if (w_ovr_set) r_overrun <= 1'b1;
    end

    // Accumulators and config share an edge: non-blocking reads give the old freq on a same-cycle write.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NCH; k++) begin
            if (rst) begin
                r_acc[k]   <= '0;
                r_freq[k]  <= '0;
                r_phase[k] <= '0;
            end else begin
                if (w_start) r_acc[k] <= r_acc[k] + r_freq[k];
                if (w_cfg_fire && bus.cfg_ch == c_CH_W'(k)) begin
                    if (bus.cfg_sel) r_phase[k] <= bus.cfg_data;
                    else             r_freq[k]  <= bus.cfg_data;
                end
            end
        end
    end

    assign w_addr = A_WIDTH'((r_acc[r_idx] + r_phase[r_idx]) >> (ACC_WIDTH - A_WIDTH));

`ifdef QUARTER_WAVE_EN
    logic [D_WIDTH-1:0] w_rom [c_Q+1];
    logic [A_WIDTH-3:0] w_r;
    logic [A_WIDTH-2:0] w_raddr;
    logic [D_WIDTH-1:0] r_s1_t;
    logic               r_s1_neg;
    logic [c_CH_W-1:0]  r_s1_ch;
    logic               r_s1_v;

    for (genvar a = 0; a <= c_Q; a++) begin : g_rom
        localparam logic [D_WIDTH-1:0] c_VAL = D_WIDTH'(quarter_val(a));
        assign w_rom[a] = c_VAL;
    end

    assign w_r     = w_addr[A_WIDTH-3:0];
    assign w_raddr = w_addr[A_WIDTH-2] ? ((A_WIDTH-1)'(c_Q) - {1'b0, w_r}) : {1'b0, w_r};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_t       <= '0;
            r_s1_neg     <= 1'b0;
            r_s1_ch      <= '0;
            r_s1_v       <= 1'b0;
            r_dout       <= '0;
            r_dout_ch    <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            r_s1_v       <= w_busy;
            r_dout_valid <= r_s1_v;
            if (w_busy) begin
                r_s1_t   <= w_rom[w_raddr];
                r_s1_neg <= w_addr[A_WIDTH-1];
                r_s1_ch  <= r_idx;
            end
            // Lower half-cycle is 2^D_WIDTH - T, i.e. the two's complement of T.
            if (r_s1_v) begin
                r_dout    <= r_s1_neg ? (~r_s1_t + 1'b1) : r_s1_t;
                r_dout_ch <= r_s1_ch;
            end
        end
    end
`else
    logic [D_WIDTH-1:0] w_rom [2**A_WIDTH];

    for (genvar a = 0; a < 2 ** A_WIDTH; a++) begin : g_rom
        localparam logic [D_WIDTH-1:0] c_VAL = D_WIDTH'(sine_val(a));
        assign w_rom[a] = c_VAL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout       <= '0;
            r_dout_ch    <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            r_dout_valid <= w_busy;
            if (w_busy) begin
                r_dout    <= w_rom[w_addr];
                r_dout_ch <= r_idx;
            end
        end
    end
`endif

    assign bus.cfg_ready  = !w_busy;
    assign bus.busy       = w_busy;
    assign bus.overrun    = r_overrun;
    assign bus.dout       = r_dout;
    assign bus.dout_ch    = r_dout_ch;
    assign bus.dout_valid = r_dout_valid;

endmodule
`default_nettype wire
